// File: rtl/serial_parity_byte_rx_pkg.sv
// Shared types and constants for the serial parity byte receiver.
//   rx_state_t : receiver FSM states
//   BYTE_W     : assembled word width
//   CNT_W      : data bit counter width (counts 0..8)
//   TMO_W      : inter-bit timeout counter width (TIMEOUT up to 255)
package serial_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PARITY,
        DONE,
        ABORT
    } rx_state_t;

    localparam int BYTE_W = 8;
    localparam int CNT_W  = 4;
    localparam int TMO_W  = 8;

endpackage

// File: rtl/serial_parity_byte_rx_if.sv
// Signal bundle between a serial bit source and the byte receiver.
//   start, bit_valid, serial_in : source -> receiver
//   register, odd               : assembled byte and its XOR reduction
//   data_valid, parity_err      : frame completion pulse and parity status
//   frame_err, busy             : timeout abort pulse and in-frame flag
// master = bit source side, slave = receiver side.
interface serial_parity_byte_rx_if;
    import serial_rx_pkg::*;

    logic              start;
    logic              bit_valid;
    logic              serial_in;
    logic [BYTE_W-1:0] register;
    logic              odd;
    logic              data_valid;
    logic              parity_err;
    logic              frame_err;
    logic              busy;

    modport master (
        output start, bit_valid, serial_in,
        input  register, odd, data_valid, parity_err, frame_err, busy
    );

    modport slave (
        input  start, bit_valid, serial_in,
        output register, odd, data_valid, parity_err, frame_err, busy
    );

endinterface

// File: rtl/serial_parity_byte_rx_detects_odd_number_of_ones.sv
// Combinational odd-ones detector.
//   data : input byte
//   odd  : 1 when data contains an odd number of ones
module detects_odd_number_of_ones
    import serial_rx_pkg::*;
(
    input  logic [BYTE_W-1:0] data,
    output logic              odd
);

    assign odd = ^data;

endmodule

// File: rtl/serial_parity_byte_rx.sv
// Serial byte receiver: shifts in 8 data bits MSB first followed by one
// parity bit, checks parity, and aborts a frame whose inter-bit gap
// reaches TIMEOUT idle cycles.
//   clk, rst_n : clock, synchronous active-low reset
//   rx         : slave side of serial_parity_byte_rx_if
// Parameters:
//   ODD_PARITY : 1 = ones over data+parity must be odd, 0 = even
//   TIMEOUT    : idle cycles between accepted bits before abort (1..255)
module serial_parity_byte_rx
    import serial_rx_pkg::*;
#(
    parameter bit          ODD_PARITY = 1'b1,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    serial_parity_byte_rx_if.slave  rx
);

    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(BYTE_W - 1);

    rx_state_t         state_q,      state_d;
    logic [BYTE_W-1:0] reg_q,        reg_d;
    logic              odd_q,        odd_d;
    logic [CNT_W-1:0]  bit_cnt_q,    bit_cnt_d;
    logic [TMO_W-1:0]  tmo_q,        tmo_d;
    logic              data_valid_q, data_valid_d;
    logic              parity_err_q, parity_err_d;
    logic              frame_err_q,  frame_err_d;
    logic              busy_q,       busy_d;

    logic              det_odd;

    always_comb begin
        state_d      = state_q;
        reg_d        = reg_q;
        odd_d        = odd_q;
        bit_cnt_d    = bit_cnt_q;
        tmo_d        = tmo_q;
        data_valid_d = 1'b0;
        parity_err_d = parity_err_q;
        frame_err_d  = 1'b0;
        busy_d       = busy_q;

        unique case (state_q)
            IDLE: begin
                if (rx.start) begin
                    state_d   = DATA;
                    reg_d     = '0;
                    odd_d     = 1'b0;
                    bit_cnt_d = '0;
                    tmo_d     = '0;
                    busy_d    = 1'b1;
                end
            end

            DATA: begin
                // Timeout has priority over a bit arriving on the same edge.
                if (tmo_q == TMO_LIMIT) begin
                    state_d     = ABORT;
                    frame_err_d = 1'b1;
                    busy_d      = 1'b0;
                end else if (rx.bit_valid) begin
                    reg_d     = {reg_q[BYTE_W-2:0], rx.serial_in};
                    // Incremental parity: drop the bit shifted out, add the new one.
                    odd_d     = odd_q ^ reg_q[BYTE_W-1] ^ rx.serial_in;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    tmo_d     = '0;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = PARITY;
                    end
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            PARITY: begin
                if (tmo_q == TMO_LIMIT) begin
                    state_d     = ABORT;
                    frame_err_d = 1'b1;
                    busy_d      = 1'b0;
                end else if (rx.bit_valid) begin
                    parity_err_d = ((odd_q ^ rx.serial_in) != ODD_PARITY);
                    state_d      = DONE;
                    data_valid_d = 1'b1;
                    busy_d       = 1'b0;
                    tmo_d        = '0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            ABORT: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            reg_q        <= '0;
            odd_q        <= 1'b0;
            bit_cnt_q    <= '0;
            tmo_q        <= '0;
            data_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            reg_q        <= reg_d;
            odd_q        <= odd_d;
            bit_cnt_q    <= bit_cnt_d;
            tmo_q        <= tmo_d;
            data_valid_q <= data_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
        end
    end

    // Downstream detector on the assembled byte; used to cross-check odd_q.
    detects_odd_number_of_ones u_odd_det (
        .data (reg_q),
        .odd  (det_odd)
    );

    odd_matches_register: assert property (@(posedge clk) odd_q == det_odd);

    assign rx.register   = reg_q;
    assign rx.odd        = odd_q;
    assign rx.data_valid = data_valid_q;
    assign rx.parity_err = parity_err_q;
    assign rx.frame_err  = frame_err_q;
    assign rx.busy       = busy_q;

endmodule
